// File: rtl/imem_pkg.sv
// imem_pkg: shared parameter defaults and FSM state encoding for the
// instruction-memory load/fetch controller (imem_ctrl).
package imem_pkg;

    // Default geometry of the external shift-in IMEM.
    localparam int IMEM_DEPTH  = 64;
    localparam int IMEM_WIDTH  = 16;
    localparam int IMEM_ADDR_W = $clog2(IMEM_DEPTH);

    // Controller states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_LOADED = 3'd2,
        ST_FETCH  = 3'd3,
        ST_DONE   = 3'd4
    } imem_ctrl_state_t;

endpackage

// File: rtl/imem_ctrl.sv
// imem_ctrl: loads a program into an external shift-in IMEM (new words enter
// entry 0) and then streams it back out in program order through a single
// output register with valid/ready handshake.
// Optional build macro IMEM_CTRL_LOOP_EN: fetch wraps from the last word back
// to pc 0 forever instead of finishing in DONE.
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int WIDTH  = IMEM_WIDTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    // program load stream
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              load_last,
    output logic              load_ready,
    // control
    input  logic              run_start,
    input  logic              abort,
    // IMEM drive (asynchronous read)
    output logic              imem_shift_enable,
    output logic [WIDTH-1:0]  imem_new_value,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [WIDTH-1:0]  imem_data_out,
    // fetch stream
    output logic              instr_valid,
    output logic [WIDTH-1:0]  instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    // status
    output logic              busy,
    output logic              done,
    output logic              err_ovf
);

    // count must be able to hold DEPTH itself, hence one extra bit.
    localparam int               CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    imem_ctrl_state_t state, state_nx;

    logic [CNT_W-1:0] count;      // words held in IMEM
    logic [CNT_W-1:0] pc;         // next program index to issue
    logic [CNT_W-1:0] rd_pc;      // program index being read this cycle
    logic [CNT_W-1:0] count_inc;
    logic [CNT_W-1:0] last_pc;

    logic take_load;   // load_start honoured this cycle
    logic take_run;    // run_start honoured this cycle
    logic accept;      // load beat accepted
    logic fill_done;   // accepted beat closes the load
    logic advance;     // output register may take a new word
    logic more;        // words remain to be issued
    logic issue;       // output register loads a word this cycle
    logic fetch_end;   // last word has left the output register

    assign count_inc = count + 1'b1;
    assign last_pc   = count - 1'b1;

    // Decode of inputs against the current state; abort masks every request.
    always_comb begin
        take_load = 1'b0;
        take_run  = 1'b0;
        accept    = 1'b0;
        fill_done = 1'b0;
        advance   = 1'b0;
        more      = 1'b0;
        issue     = 1'b0;
        fetch_end = 1'b0;
        rd_pc     = '0;

        if (!abort) begin
            take_load = load_start &&
                        (state == ST_IDLE || state == ST_LOADED || state == ST_DONE);
            // load_start wins a tie with run_start; an empty program never runs.
            take_run  = run_start && !load_start &&
                        (state == ST_LOADED || state == ST_DONE) && (count != '0);
            accept    = (state == ST_LOAD) && load_valid && (count < DEPTH_C);
        end

        fill_done = accept && (load_last || (count_inc == DEPTH_C));
        advance   = !instr_valid || instr_ready;

`ifdef IMEM_CTRL_LOOP_EN
        more = 1'b1;
`else
        more = (pc < count);
`endif

        issue     = take_run || ((state == ST_FETCH) && !abort && advance && more);
        fetch_end = (state == ST_FETCH) && !abort && advance && !more;

        // Fetch starts at pc 0 in the same cycle run_start is seen so the first
        // word is valid one cycle later. Once everything is issued the read
        // index parks on the last word so imem_addr stays put while it waits.
        if (take_run) begin
            rd_pc = '0;
        end else if (more) begin
            rd_pc = pc;
        end else begin
            rd_pc = last_pc;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; abort returns to IDLE from anywhere.
    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take_load) state_nx = ST_LOAD;
                end
                ST_LOAD: begin
                    if (fill_done) state_nx = ST_LOADED;
                end
                ST_LOADED, ST_DONE: begin
                    if (take_load)     state_nx = ST_LOAD;
                    else if (take_run) state_nx = ST_FETCH;
                end
                ST_FETCH: begin
                    if (fetch_end) state_nx = ST_DONE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // Moore status plus the combinational IMEM write/read drive.
    always_comb begin
        load_ready        = 1'b0;
        imem_shift_enable = 1'b0;
        imem_new_value    = '0;
        imem_addr         = '0;
        busy              = 1'b0;
        done              = 1'b0;

        case (state)
            ST_LOAD: begin
                load_ready = (count < DEPTH_C);
                busy       = 1'b1;
            end
            ST_FETCH: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default: ;
        endcase

        if (accept) begin
            imem_shift_enable = 1'b1;
            imem_new_value    = load_data;
        end

        // The first loaded word sits deepest in IMEM: entry count-1-pc.
        if (state == ST_FETCH || take_run) begin
            imem_addr = ADDR_W'(last_pc - rd_pc);
        end
    end

    // Word count and sticky overflow flag; both survive abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            err_ovf <= 1'b0;
        end else if (take_load) begin
            count   <= '0;
            err_ovf <= 1'b0;
        end else if (accept) begin
            count <= count_inc;
            if ((count_inc == DEPTH_C) && !load_last) begin
                err_ovf <= 1'b1;
            end
        end
    end

    // Fetch pointer and the single output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= '0;
            instr_valid <= 1'b0;
            instr_data  <= '0;
            instr_pc    <= '0;
        end else if (abort) begin
            instr_valid <= 1'b0;
        end else if (issue) begin
            instr_valid <= 1'b1;
            instr_data  <= imem_data_out;
            instr_pc    <= ADDR_W'(rd_pc);
`ifdef IMEM_CTRL_LOOP_EN
            pc          <= (rd_pc == last_pc) ? '0 : rd_pc + 1'b1;
`else
            pc          <= rd_pc + 1'b1;
`endif
        end else if (fetch_end) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: scoreboard bench for imem_ctrl with a behavioural shift-in
// IMEM. Stimulus pushes the expected fetch stream (program order) into a
// queue; the monitor pops on every handshake and owns all pass/fail counters.
module tb_imem_ctrl;
    import imem_pkg::*;

    localparam int DEPTH  = 64;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              load_start = 1'b0;
    logic              load_valid = 1'b0;
    logic [WIDTH-1:0]  load_data  = '0;
    logic              load_last  = 1'b0;
    logic              run_start  = 1'b0;
    logic              abort      = 1'b0;
    logic              instr_ready;
    logic              load_ready, imem_shift_enable, instr_valid, busy, done, err_ovf;
    logic [WIDTH-1:0]  imem_new_value, imem_data_out, instr_data;
    logic [ADDR_W-1:0] imem_addr, instr_pc;

    always #5 clk = ~clk;

    imem_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready),
        .run_start(run_start), .abort(abort),
        .imem_shift_enable(imem_shift_enable), .imem_new_value(imem_new_value),
        .imem_addr(imem_addr), .imem_data_out(imem_data_out),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .busy(busy), .done(done), .err_ovf(err_ovf)
    );

    // Behavioural IMEM: shift in at entry 0, asynchronous read.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (imem_shift_enable) begin
            for (int i = DEPTH - 1; i > 0; i--) mem[i] <= mem[i-1];
            mem[0] <= imem_new_value;
        end
    end
    assign imem_data_out = mem[imem_addr];

    // Shared stimulus / scoreboard state
    logic [ADDR_W+WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0]        stim[$];
    logic [WIDTH-1:0]        ref_prog[$];
    string                   cn_q[$];
    int                      ca_q[$];
    int                      ce_q[$];
    bit                      strict = 1'b1;
    bit                      finish_req = 1'b0;
    int                      ready_mode = 0;
    int                      shift_total = 0;

    // Ready driver: 0 always ready, 1 random, 2 stall 3 cycles on pc 1.
    always @(posedge clk) begin
        int st_cnt;
        #1;
        case (ready_mode)
            0: instr_ready = 1'b1;
            1: instr_ready = ($urandom_range(0, 2) != 0);
            default: begin
                if (instr_valid && instr_pc == 1 && st_cnt < 3) begin
                    instr_ready = 1'b0;
                    st_cnt++;
                end else begin
                    instr_ready = 1'b1;
                end
            end
        endcase
        if (ready_mode != 2) st_cnt = 0;
    end

    // Monitor: scoreboard pops, hold checks, queued directed checks, summary.
    int               checks = 0;
    int               failures = 0;
    int               cyc = 0;
    bit               prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic [ADDR_W-1:0] prev_pc, prev_addr;
    always @(negedge clk) begin
        logic [ADDR_W+WIDTH-1:0] e;
        string nm;
        int a, x;
        cyc++;
        if (imem_shift_enable) begin
            shift_total++;
            checks++;
            if (imem_new_value !== load_data) begin
                failures++;
                $display("FAIL shift_value: got %h expected %h", imem_new_value, load_data);
            end
        end
        if (rst && prev_stall) begin
            checks++;
            if (!instr_valid || instr_data !== prev_data || instr_pc !== prev_pc ||
                imem_addr !== prev_addr) begin
                failures++;
                $display("FAIL hold: got v=%0d d=%h pc=%0d a=%0d expected v=1 d=%h pc=%0d a=%0d",
                         instr_valid, instr_data, instr_pc, imem_addr, prev_data, prev_pc, prev_addr);
            end
        end
        if (rst && instr_valid && instr_ready && !abort) begin
            if (exp_q.size() == 0) begin
                if (strict) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_word: got pc=%0d data=%h expected none", instr_pc, instr_data);
                end
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (instr_pc !== e[WIDTH +: ADDR_W] || instr_data !== e[WIDTH-1:0]) begin
                    failures++;
                    $display("FAIL fetch: got pc=%0d data=%h expected pc=%0d data=%h",
                             instr_pc, instr_data, e[WIDTH +: ADDR_W], e[WIDTH-1:0]);
                end
            end
        end
        prev_stall = rst && instr_valid && !instr_ready && !abort;
        prev_data  = instr_data;
        prev_pc    = instr_pc;
        prev_addr  = imem_addr;
        while (cn_q.size() != 0) begin
            nm = cn_q.pop_front();
            a  = ca_q.pop_front();
            x  = ce_q.pop_front();
            checks++;
            if (a != x) begin
                failures++;
                $display("FAIL %s: got %0d expected %0d", nm, a, x);
            end
        end
        if (cyc > 80000) begin
            failures++;
            $display("FAIL timeout: got %0d cycles expected completion", cyc);
        end
        if (finish_req || cyc > 80000) begin
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic chk(input string n, input int a, input int x);
        cn_q.push_back(n);
        ca_q.push_back(a);
        ce_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load stim[0..n-1]; reference: words kept until load_last or DEPTH reached.
    task automatic load_prog(input int n, input int last_idx, input bit gaps);
        int i, rej, guard, base;
        bit exp_err;
        ref_prog.delete();
        for (int k = 0; k < n; k++) begin
            ref_prog.push_back(stim[k]);
            if (k == last_idx || ref_prog.size() == DEPTH) break;
        end
        exp_err = (ref_prog.size() == DEPTH) && (last_idx != DEPTH - 1);
        tick();
        base = shift_total;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        i = 0; rej = 0; guard = 0;
        while (i < n && rej < 5 && guard < 5000) begin
            load_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            load_data  = stim[i];
            load_last  = (i == last_idx);
            @(negedge clk);
            if (load_valid) begin
                if (load_ready) i++;
                else rej++;
            end
            tick();
            guard++;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        @(negedge clk);
        chk("load_shifts", shift_total - base, ref_prog.size());
        chk("load_count", int'(dut.count), ref_prog.size());
        chk("load_err_ovf", int'(err_ovf), int'(exp_err));
        chk("load_state", int'(dut.state), int'(ST_LOADED));
        chk("load_ready_low", int'(load_ready), 0);
        chk("load_busy_low", int'(busy), 0);
    endtask

    // Run ref_prog; expected stream is program order with pc = index.
    task automatic run_prog(input int rmode, input bit chk_addr);
        int n, c;
        n = ref_prog.size();
        tick();
`ifdef IMEM_CTRL_LOOP_EN
        strict = 1'b0;
        for (int k = 0; k < 2 * n + 1; k++)
            exp_q.push_back({ADDR_W'(k % n), ref_prog[k % n]});
`else
        strict = 1'b1;
        for (int k = 0; k < n; k++)
            exp_q.push_back({ADDR_W'(k), ref_prog[k]});
`endif
        ready_mode = rmode;
        run_start  = 1'b1;
        @(negedge clk);
        if (chk_addr) chk("addr_pc0", int'(imem_addr), n - 1);
        tick();
        run_start = 1'b0;
        @(negedge clk);
        chk("first_valid", int'(instr_valid), 1);
        chk("first_pc", int'(instr_pc), 0);
        if (chk_addr) begin
            for (int k = 1; k < n; k++) begin
                chk($sformatf("addr_pc%0d", k), int'(imem_addr), n - 1 - k);
                @(negedge clk);
            end
        end
`ifdef IMEM_CTRL_LOOP_EN
        for (c = 0; c < 20000 && exp_q.size() != 0; c++) @(negedge clk);
        chk("loop_drained", exp_q.size(), 0);
        chk("loop_done_low", int'(done), 0);
        chk("loop_busy", int'(busy), 1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("loop_abort_idle", int'(dut.state), int'(ST_IDLE));
        chk("loop_abort_valid", int'(instr_valid), 0);
        exp_q.delete();
`else
        for (c = 0; c < 20000 && !done; c++) @(negedge clk);
        chk("run_done", int'(done), 1);
        chk("run_drained", exp_q.size(), 0);
        chk("run_valid_low", int'(instr_valid), 0);
        chk("run_busy_low", int'(busy), 0);
`endif
        ready_mode = 0;
    endtask

    initial begin
        int n, last, c;
        logic [WIDTH-1:0] w;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(instr_valid), 0);
        chk("rst_data", int'(instr_data), 0);
        chk("rst_pc", int'(instr_pc), 0);
        chk("rst_addr", int'(imem_addr), 0);
        chk("rst_shift", int'(imem_shift_enable), 0);
        chk("rst_ready", int'(load_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err_ovf), 0);
        rst = 1'b1;
        tick();

        // three-word program, free-running consumer
        stim.delete();
        w = 16'hAAAA; stim.push_back(w);
        w = 16'hBBBB; stim.push_back(w);
        w = 16'hCCCC; stim.push_back(w);
        load_prog(3, 2, 1'b0);
        run_prog(0, 1'b1);

        // backpressure on the second word
        load_prog(3, 2, 1'b0);
        run_prog(2, 1'b0);

        // overflow: 65 beats, no load_last
        stim.delete();
        for (int k = 0; k < 65; k++) begin
            w = WIDTH'($urandom);
            stim.push_back(w);
        end
        load_prog(65, -1, 1'b0);
        run_prog(1, 1'b0);
        chk("ovf_sticky", int'(err_ovf), 1);
`ifdef IMEM_CTRL_LOOP_EN
        load_prog(65, -1, 1'b0);
`endif
        // load_start and run_start together: load wins, count and err clear
        tick();
        load_start = 1'b1;
        run_start  = 1'b1;
        tick();
        load_start = 1'b0;
        run_start  = 1'b0;
        @(negedge clk);
        chk("tie_state_load", int'(dut.state), int'(ST_LOAD));
        chk("tie_count", int'(dut.count), 0);
        chk("tie_err_clear", int'(err_ovf), 0);
        chk("tie_valid", int'(instr_valid), 0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // reset mid-fetch at pc 1
        stim.delete();
        w = 16'h1234; stim.push_back(w);
        w = 16'h5678; stim.push_back(w);
        w = 16'h9ABC; stim.push_back(w);
        load_prog(3, 2, 1'b0);
        tick();
        strict     = 1'b0;
        ready_mode = 0;
        run_start  = 1'b1;
        tick();
        run_start = 1'b0;
        for (c = 0; c < 20 && !(instr_valid && instr_pc == 1); c++) @(negedge clk);
        chk("mid_fetch_pc1", int'(instr_valid && instr_pc == 1), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", int'(instr_valid), 0);
        chk("arst_data", int'(instr_data), 0);
        chk("arst_pc", int'(instr_pc), 0);
        chk("arst_addr", int'(imem_addr), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_count", int'(dut.count), 0);
        chk("arst_state", int'(dut.state), int'(ST_IDLE));
        tick();
        rst = 1'b1;
        exp_q.delete();
        strict = 1'b1;
        // run_start ignored in IDLE
        tick();
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        @(negedge clk);
        chk("idle_run_ignored", int'(dut.state), int'(ST_IDLE));
        chk("idle_run_no_valid", int'(instr_valid), 0);

        // abort mid-load keeps count
        tick();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = 16'h1111;
        tick();
        load_data  = 16'h2222;
        tick();
        load_valid = 1'b0;
        abort      = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_load_idle", int'(dut.state), int'(ST_IDLE));
        chk("abort_load_count", int'(dut.count), 2);
        chk("abort_load_ready", int'(load_ready), 0);
        chk("abort_load_busy", int'(busy), 0);

        // randomized programs, gaps on load, random consumer stalls
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 70);
            if (n <= DEPTH)                    last = n - 1;
            else if ($urandom_range(0, 1) != 0) last = $urandom_range(0, n - 1);
            else                               last = -1;
            stim.delete();
            for (int k = 0; k < n; k++) begin
                w = WIDTH'($urandom);
                stim.push_back(w);
            end
            load_prog(n, last, 1'b1);
            run_prog(1, 1'b0);
        end

        finish_req = 1'b1;
        repeat (5) @(negedge clk);
    end

endmodule
